// File: rtl/sort_pkg.sv
// sort_pkg: shared types and constants for the cocktail sort engine and its renderers
//   sort_state_t  engine state encoding (IDLE/READY/SORT/DONE)
//   DIR_FWD/BWD   pass direction as exported on dir_o
//   COL_*         RGB565 bar colours shared by the OLED renderers
//   rotl16        16-bit rotate-left used to spread LFSR bits across elements
package sort_pkg;
    typedef enum logic [1:0] {S_IDLE, S_READY, S_SORT, S_DONE} sort_state_t;
    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;
    localparam logic [15:0] COL_BG    = 16'h0000;
    localparam logic [15:0] COL_BAR   = 16'hFFFF;
    localparam logic [15:0] COL_CMP   = 16'hF800;
    localparam logic [15:0] COL_SWAP  = 16'hFFE0;
    localparam logic [15:0] COL_FINAL = 16'h07E0;
    function automatic logic [15:0] rotl16(input logic [15:0] v, input int unsigned s);
        logic [31:0] d;
        d = {v, v} << (s % 16);
        return d[31:16];
    endfunction
endpackage

// File: rtl/step_tick_gen.sv
// step_tick_gen: paces sort steps; auto tick every STEP_DELAY cycles or manual single-step
//   clk, reset_n  clock, async active-low reset
//   clr           hold the counter at zero (engine not sorting)
//   run           1 = free-running pacing, 0 = paused (counter holds)
//   step          single-step request, honoured only while paused
//   tick          one-cycle step enable
module step_tick_gen #(
    parameter int STEP_DELAY = 100000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic run,
    input  logic step,
    output logic tick
);
    localparam int CW = $clog2(STEP_DELAY + 1);
    localparam logic [CW-1:0] LAST = CW'(STEP_DELAY - 1);
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (run) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
    assign tick = run ? (cnt == LAST) : step;
endmodule

// File: rtl/cocktail_sort_engine.sv
// cocktail_sort_engine: N-element ascending cocktail-shaker sort, one compare/swap per step
//   load_i/load_rand_i/init_data_i  load array (bus or LFSR) and go READY
//   start_i, run_i, step_i          start sorting, auto pacing, manual single step
//   data_o                          array, element k at [k*W +: W]
//   cmp_idx_o, lo_o, hi_o, dir_o    compare cursor, active window, pass direction
//   swap_o, busy_o, done_o          swap pulse, SORT state, DONE state
//   cmp_cnt_o, swap_cnt_o           saturating statistics since last load
module cocktail_sort_engine
    import sort_pkg::*;
#(
    parameter int N = 5,
    parameter int W = 7,
    parameter int STEP_DELAY = 100000000,
    parameter int CNT_W = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    localparam int IW = $clog2(N)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             load_rand_i,
    input  logic [N*W-1:0]   init_data_i,
    input  logic             start_i,
    input  logic             run_i,
    input  logic             step_i,
    output logic [N*W-1:0]   data_o,
    output logic [IW-1:0]    cmp_idx_o,
    output logic [IW-1:0]    lo_o,
    output logic [IW-1:0]    hi_o,
    output logic             dir_o,
    output logic             swap_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] cmp_cnt_o,
    output logic [CNT_W-1:0] swap_cnt_o
);
    localparam logic [IW-1:0] HI_INIT = IW'(N - 1);
    sort_state_t state, state_n;
    logic [W-1:0] arr [N];
    logic [W-1:0] load_val [N];
    logic [IW-1:0] j, jp1, lo, hi, j_n, lo_n, hi_n;
    logic dir, dir_n, pass_sw, tick, step_en, do_swap, ps_eff, at_end, finish, not_sorting;
    logic [15:0] lfsr;
    assign not_sorting = state != S_SORT;
    step_tick_gen #(.STEP_DELAY(STEP_DELAY)) u_tick (
        .clk(clk), .reset_n(reset_n), .clr(not_sorting), .run(run_i), .step(step_i), .tick(tick)
    );
    always_comb begin
        jp1 = j + 1'b1;
        step_en = (state == S_SORT) && tick && !load_i;
        do_swap = arr[j] > arr[jp1];
        // the swap made by this very step counts toward the pass result
        ps_eff = pass_sw | do_swap;
        at_end = (dir == DIR_FWD) ? (j == hi - 1'b1) : (j == lo);
        hi_n = (dir == DIR_FWD && at_end && ps_eff) ? hi - 1'b1 : hi;
        lo_n = (dir == DIR_BWD && at_end && ps_eff) ? lo + 1'b1 : lo;
        dir_n = (at_end && ps_eff) ? ~dir : dir;
        // turnaround lands directly on the first pair of the next pass, so no idle step
        j_n = !at_end ? ((dir == DIR_FWD) ? jp1 : j - 1'b1)
                      : ((dir == DIR_FWD) ? hi_n - 1'b1 : lo_n);
        finish = at_end && (!ps_eff || lo_n >= hi_n);
        state_n = load_i ? S_READY
                : (state == S_READY && start_i) ? S_SORT
                : (step_en && finish) ? S_DONE : state;
        for (int k = 0; k < N; k++)
            load_val[k] = load_rand_i ? W'(rotl16(lfsr, 3 * k)) : init_data_i[k*W +: W];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else state <= state_n;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < N; k++) arr[k] <= '0;
            j <= '0;
            lo <= '0;
            hi <= HI_INIT;
            dir <= DIR_FWD;
            pass_sw <= 1'b0;
            swap_o <= 1'b0;
            cmp_cnt_o <= '0;
            swap_cnt_o <= '0;
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            swap_o <= 1'b0;
            if (load_i) begin
                for (int k = 0; k < N; k++) arr[k] <= load_val[k];
                j <= '0;
                lo <= '0;
                hi <= HI_INIT;
                dir <= DIR_FWD;
                pass_sw <= 1'b0;
                cmp_cnt_o <= '0;
                swap_cnt_o <= '0;
            end else if (step_en) begin
                if (do_swap) begin
                    arr[j] <= arr[jp1];
                    arr[jp1] <= arr[j];
                    swap_cnt_o <= (&swap_cnt_o) ? swap_cnt_o : swap_cnt_o + 1'b1;
                end
                cmp_cnt_o <= (&cmp_cnt_o) ? cmp_cnt_o : cmp_cnt_o + 1'b1;
                swap_o <= do_swap;
                pass_sw <= at_end ? 1'b0 : ps_eff;
                j <= j_n;
                lo <= lo_n;
                hi <= hi_n;
                dir <= dir_n;
            end
        end
    end
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign data_o[g*W +: W] = arr[g];
    end
    assign cmp_idx_o = j;
    assign lo_o = lo;
    assign hi_o = hi;
    assign dir_o = dir;
    assign busy_o = state == S_SORT;
    assign done_o = state == S_DONE;
endmodule

// File: tb/tb_cocktail_sort_engine.sv
// tb_cocktail_sort_engine: randomized self-checking bench against a loop-based cocktail sort model
module tb_cocktail_sort_engine;
    localparam int N = 5;
    localparam int W = 7;
    localparam int IW = $clog2(N);
    typedef int arr_t [N];
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic load_i = 1'b0, load_rand_i = 1'b0, start_i = 1'b0, run_i = 1'b0, step_i = 1'b0;
    logic [N*W-1:0] init_data_i = '0;
    logic [N*W-1:0] data_o;
    logic [IW-1:0] cmp_idx_o, lo_o, hi_o;
    logic dir_o, swap_o, busy_o, done_o;
    logic [15:0] cmp_cnt_o, swap_cnt_o;
    int total = 0;
    int bad = 0;
    cocktail_sort_engine #(.N(N), .W(W), .STEP_DELAY(4), .CNT_W(16), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset_n(reset_n), .load_i(load_i), .load_rand_i(load_rand_i),
        .init_data_i(init_data_i), .start_i(start_i), .run_i(run_i), .step_i(step_i),
        .data_o(data_o), .cmp_idx_o(cmp_idx_o), .lo_o(lo_o), .hi_o(hi_o), .dir_o(dir_o),
        .swap_o(swap_o), .busy_o(busy_o), .done_o(done_o),
        .cmp_cnt_o(cmp_cnt_o), .swap_cnt_o(swap_cnt_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    function automatic logic [N*W-1:0] pack(input arr_t v);
        logic [N*W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(v[k]);
        return r;
    endfunction
    task automatic unpack(input logic [N*W-1:0] d, output arr_t r);
        for (int k = 0; k < N; k++) r[k] = int'(d[k*W +: W]);
    endtask
    task automatic sorted_pack(input arr_t v, output logic [N*W-1:0] r);
        int q[$];
        for (int k = 0; k < N; k++) q.push_back(v[k]);
        q.sort();
        r = '0;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(q[k]);
    endtask
    // Reference: plain nested-loop cocktail sort with early exit; swaps equal inversion count
    task automatic ref_sort(input arr_t v, output int cmps, output int inv);
        arr_t a;
        int lo, hi, t;
        bit sw, go;
        a = v;
        cmps = 0;
        inv = 0;
        for (int i = 0; i < N; i++)
            for (int k = i + 1; k < N; k++) if (v[i] > v[k]) inv++;
        lo = 0;
        hi = N - 1;
        go = 1;
        while (go) begin
            sw = 0;
            for (int p = lo; p < hi; p++) begin
                cmps++;
                if (a[p] > a[p+1]) begin t = a[p]; a[p] = a[p+1]; a[p+1] = t; sw = 1; end
            end
            hi--;
            if (!sw || lo >= hi) go = 0;
            if (go) begin
                sw = 0;
                for (int p = hi - 1; p >= lo; p--) begin
                    cmps++;
                    if (a[p] > a[p+1]) begin t = a[p]; a[p] = a[p+1]; a[p+1] = t; sw = 1; end
                end
                lo++;
                if (!sw || lo >= hi) go = 0;
            end
        end
    endtask
    task automatic do_load(input arr_t v, input logic rnd);
        @(negedge clk);
        init_data_i = pack(v);
        load_rand_i = rnd;
        load_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        load_rand_i = 1'b0;
    endtask
    task automatic do_start;
        @(negedge clk) start_i = 1'b1;
        @(negedge clk) start_i = 1'b0;
    endtask
    task automatic step1(output logic sw);
        @(negedge clk) step_i = 1'b1;
        @(negedge clk) step_i = 1'b0;
        sw = swap_o;
    endtask
    task automatic sort_out(output int pulses);
        logic sw;
        pulses = 0;
        for (int i = 0; i < 60 && !done_o; i++) begin
            step1(sw);
            pulses += int'(sw);
        end
        chk("sort_timeout", done_o, 1);
    endtask
    task automatic verify(input string tag, input arr_t v);
        int cmps, inv, pulses;
        logic [N*W-1:0] exp;
        ref_sort(v, cmps, inv);
        sorted_pack(v, exp);
        do_start;
        sort_out(pulses);
        chk({tag, "_data"}, data_o, exp);
        chk({tag, "_cmp"}, cmp_cnt_o, cmps);
        chk({tag, "_swap"}, swap_cnt_o, inv);
        chk({tag, "_pulses"}, pulses, inv);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
    initial begin
        arr_t v, r1, r2;
        logic sw;
        int cmps, inv;
        // reset state
        #12;
        chk("rst_data", data_o, 0);
        chk("rst_idx", cmp_idx_o, 0);
        chk("rst_lo", lo_o, 0);
        chk("rst_hi", hi_o, N - 1);
        chk("rst_flags", {dir_o, swap_o, busy_o, done_o}, 0);
        chk("rst_cnt", {cmp_cnt_o, swap_cnt_o}, 0);
        @(negedge clk) reset_n = 1'b1;
        // reversed input: every compare swaps
        v = '{5, 4, 3, 2, 1};
        do_load(v, 1'b0);
        chk("t1_loaded", data_o, pack(v));
        chk("t1_ready", {busy_o, done_o}, 0);
        do_start;
        chk("t1_busy", busy_o, 1);
        step1(sw);
        chk("t1_first_swap", sw, 1);
        chk("t1_idx", cmp_idx_o, 1);
        repeat (9) step1(sw);
        chk("t1_done", done_o, 1);
        chk("t1_data", data_o, pack('{1, 2, 3, 4, 5}));
        chk("t1_cmp", cmp_cnt_o, 10);
        chk("t1_swap", swap_cnt_o, 10);
        chk("t1_lo", lo_o, 2);
        // DONE holds against start/step
        do_start;
        step1(sw);
        chk("t1_hold", {done_o, data_o}, {1'b1, pack('{1, 2, 3, 4, 5})});
        chk("t1_hold_cmp", cmp_cnt_o, 10);
        // already sorted: early exit after one forward pass
        do_load('{1, 2, 3, 4, 5}, 1'b0);
        do_start;
        repeat (3) step1(sw);
        chk("t2_not_yet", done_o, 0);
        step1(sw);
        chk("t2_done", done_o, 1);
        chk("t2_cnt", {cmp_cnt_o, swap_cnt_o}, {16'd4, 16'd0});
        chk("t2_win", {lo_o, hi_o}, {3'd0, 3'd4});
        // equal keys never swap
        v = '{3, 3, 1, 3, 2};
        do_load(v, 1'b0);
        verify("t3", v);
        chk("t3_exact", data_o, pack('{1, 2, 3, 3, 3}));
        // auto pacing
        do_load('{5, 4, 3, 2, 1}, 1'b0);
        @(negedge clk) run_i = 1'b1;
        do_start;
        repeat (3) begin
            @(negedge clk);
            chk("t4_early", swap_o, 0);
        end
        @(negedge clk);
        chk("t4_first_swap", swap_o, 1);
        run_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("t4_paused_data", data_o, pack('{4, 5, 3, 2, 1}));
        chk("t4_paused_cmp", cmp_cnt_o, 1);
        step1(sw);
        chk("t4_step_data", data_o, pack('{4, 3, 5, 2, 1}));
        chk("t4_step_cmp", cmp_cnt_o, 2);
        // load beats a simultaneous step
        @(negedge clk);
        init_data_i = pack('{9, 8, 7, 6, 5});
        load_i = 1'b1;
        step_i = 1'b1;
        @(negedge clk);
        load_i = 1'b0;
        step_i = 1'b0;
        chk("t5_data", data_o, pack('{9, 8, 7, 6, 5}));
        chk("t5_cnt", {cmp_cnt_o, swap_cnt_o}, 0);
        chk("t5_ready", {busy_o, done_o, cmp_idx_o}, 0);
        // async reset mid-sort
        do_start;
        step1(sw);
        step1(sw);
        chk("t5_swapped", sw, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_data", data_o, 0);
        chk("t5_rst_flags", {swap_o, busy_o, done_o, dir_o}, 0);
        chk("t5_rst_win", {cmp_idx_o, lo_o, hi_o}, {3'd0, 3'd0, 3'd4});
        chk("t5_rst_cnt", {cmp_cnt_o, swap_cnt_o}, 0);
        @(negedge clk) reset_n = 1'b1;
        // LFSR loads
        v = '{0, 0, 0, 0, 0};
        repeat ($urandom_range(1, 7)) @(negedge clk);
        do_load(v, 1'b1);
        unpack(data_o, r1);
        verify("rand1", r1);
        repeat ($urandom_range(1, 7)) @(negedge clk);
        do_load(v, 1'b1);
        unpack(data_o, r2);
        chk("rand_differ", pack(r1) != pack(r2), 1);
        verify("rand2", r2);
        // random bus loads with many duplicates
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < N; k++) v[k] = $urandom_range(0, (t % 2) ? 127 : 4);
            do_load(v, 1'b0);
            chk("rnd_loaded", data_o, pack(v));
            verify("rnd", v);
        end
        ref_sort('{2, 1, 3, 4, 5}, cmps, inv);
        do_load('{2, 1, 3, 4, 5}, 1'b0);
        verify("near_sorted", '{2, 1, 3, 4, 5});
        chk("near_sorted_cmp", cmp_cnt_o, 7);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
